// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle add/sub/shift/logic ops plus an iterative shift-add multiply.
// Define ALU_DIV_EN to turn op 6 into an N-cycle restoring unsigned divide instead of bitwise AND.
module alu_mc #(
    parameter int N     = 16,
    parameter int SHIFT = 8,
    parameter int Z_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in1,
    input  logic [N-1:0]   in2,
    input  logic [2:0]     alu_op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   alu_out,
    output logic [Z_W-1:0] z,
    output logic           busy,
    output logic [1:0]     state_o
);
    // Handshake: a beat moves on a port exactly in a cycle where its valid and ready are both high
    // at the rising edge; valid never depends on ready, and in_ready is combinational from slot state.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  alu_out_q, alu_out_d;
    logic          z_q, z_d;

    logic          fire, start_mul, start_div, single, done, load;
    logic [N-1:0]  single_res, mc_res, load_val, mul_sum;

    assign in_ready  = !rst && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign fire      = in_valid && in_ready;
    assign start_mul = fire && (alu_op == 3'd3);
`ifdef ALU_DIV_EN
    assign start_div = fire && (alu_op == 3'd6);
`else
    assign start_div = 1'b0;
`endif
    assign single    = fire && !start_mul && !start_div;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_mul)      state_d = S_MUL;
                else if (start_div) state_d = S_DIV;
            end
            S_MUL, S_DIV: if (cnt_q == LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == S_MUL) || (state_q == S_DIV);
        done    = busy && (cnt_q == LAST);
        state_o = state_q;
    end

    always_comb begin
        single_res = '0;
        case (alu_op)
            3'd0: single_res = in1;
            3'd1: single_res = in1 + in2;
            3'd2: single_res = in1 - in2;
            3'd4: single_res = in1 << SHIFT;
            3'd5: single_res = in1 >> SHIFT;
            3'd6: single_res = in1 & in2;
            3'd7: single_res = in1 | in2;
            default: single_res = '0;
        endcase
    end

    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef ALU_DIV_EN
    // Divide reuses acc as remainder, mcand as divisor, mplier as dividend/quotient shift register.
    logic [N:0]   rem_shift, trial;
    logic         q_bit;
    logic [N-1:0] quo_next;
    assign rem_shift = {acc_q, mplier_q[N-1]};
    assign q_bit     = rem_shift >= {1'b0, mcand_q};
    assign trial     = rem_shift - {1'b0, mcand_q};
    assign quo_next  = {mplier_q[N-2:0], q_bit};
    assign mc_res    = (state_q == S_DIV) ? quo_next : mul_sum;
`else
    assign mc_res    = mul_sum;
`endif

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start_mul) begin
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = in1;
            mplier_d = in2;
        end else if (start_div) begin
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = in2;
            mplier_d = in1;
        end else if (state_q == S_MUL) begin
            cnt_d    = done ? '0 : cnt_q + CW'(1);
            acc_d    = mul_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
`ifdef ALU_DIV_EN
        else if (state_q == S_DIV) begin
            cnt_d    = done ? '0 : cnt_q + CW'(1);
            acc_d    = q_bit ? trial[N-1:0] : rem_shift[N-1:0];
            mplier_d = quo_next;
        end
`endif
    end

    // Output slot: a load beats a simultaneous drain so back-to-back results never drop valid.
    assign load     = single || done;
    assign load_val = done ? mc_res : single_res;

    always_comb begin
        out_valid_d = out_valid_q;
        alu_out_d   = alu_out_q;
        z_d         = z_q;
        if (load) begin
            out_valid_d = 1'b1;
            alu_out_d   = load_val;
            z_d         = (load_val == '0);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            z_q         <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            z_q         <= z_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign z         = Z_W'(z_q);
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: vector table for single-cycle ops, hand sequences for multiply,
// reset abort, backpressure and (with ALU_DIV_EN) divide.
module tb_alu_mc;
    localparam int N     = 16;
    localparam int SHIFT = 8;
    localparam int Z_W   = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   in1 = '0;
    logic [N-1:0]   in2 = '0;
    logic [2:0]     alu_op = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [N-1:0]   alu_out;
    logic [Z_W-1:0] z;
    logic           busy;
    logic [1:0]     state_o;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] res;
        logic         zf;
    } vec_t;

    vec_t vecs[$];

    alu_mc #(.N(N), .SHIFT(SHIFT), .Z_W(Z_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .alu_op(alu_op), .out_valid(out_valid),
        .out_ready(out_ready), .alu_out(alu_out), .z(z), .busy(busy), .state_o(state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        alu_op   = op;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in1      = $urandom_range(0, 65535);
        in2      = $urandom_range(0, 65535);
    endtask

    // scoreboard compare of the slot against the oldest expected result
    task automatic expect_result(input string name, input logic zf);
        logic [N-1:0] e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, " valid"}, {31'd0, out_valid}, 32'd1);
            check({name, " alu_out"}, {16'd0, alu_out}, {16'd0, e});
            check({name, " z"}, {16'd0, z}, {31'd0, zf});
        end
    endtask

    // multi-cycle op with fixed latency N; operands are scrambled after the transfer
    task automatic run_multi(input string name, input logic [2:0] op, input logic [N-1:0] a,
                             input logic [N-1:0] b, input logic [N-1:0] res, input logic zf);
        int busy_cycles;
        int ready_seen;
        check({name, " in_ready pre"}, {31'd0, in_ready}, 32'd1);
        drive(op, a, b);
        exp_q.push_back(res);
        tick();
        idle();
        busy_cycles = 0;
        ready_seen  = 0;
        for (int k = 0; k < N; k++) begin
            if (busy) busy_cycles++;
            if (in_ready) ready_seen++;
            if (k < N - 1) tick();
        end
        check({name, " busy cycles"}, busy_cycles, N);
        check({name, " in_ready during"}, ready_seen, 0);
        check({name, " early valid"}, {31'd0, out_valid}, 32'd0);
        tick();
        expect_result(name, zf);
        check({name, " busy after"}, {31'd0, busy}, 32'd0);
        tick();
        check({name, " drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int leaked;
        vecs.push_back('{3'd1, 16'h0005, 16'h0003, 16'h0008, 1'b0});
        vecs.push_back('{3'd2, 16'h0003, 16'h0003, 16'h0000, 1'b1});
        vecs.push_back('{3'd2, 16'h0000, 16'h0001, 16'hFFFF, 1'b0});
        vecs.push_back('{3'd4, 16'h12F0, 16'h0000, 16'hF000, 1'b0});
        vecs.push_back('{3'd5, 16'h12F0, 16'h0000, 16'h0012, 1'b0});
        vecs.push_back('{3'd0, 16'hABCD, 16'h1234, 16'hABCD, 1'b0});
        vecs.push_back('{3'd7, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b0});
        vecs.push_back('{3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1});
`ifndef ALU_DIV_EN
        vecs.push_back('{3'd6, 16'h0F0F, 16'h00FF, 16'h000F, 1'b0});
`endif

        // reset values
        in_valid = 1'b1;
        tick();
        check("rst in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst alu_out", {16'd0, alu_out}, 32'd0);
        check("rst z", {16'd0, z}, 32'd1);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst state", {30'd0, state_o}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        tick();

        // reset aborts a multiply in flight
        drive(3'd3, 16'h0003, 16'h0005);
        tick();
        idle();
        check("abort busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort alu_out", {16'd0, alu_out}, 32'd0);
        check("abort z", {16'd0, z}, 32'd1);
        check("abort busy after", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        leaked = 0;
        for (int k = 0; k < N + 4; k++) begin
            tick();
            if (out_valid || busy) leaked++;
        end
        check("abort no result", leaked, 0);

        // back-to-back single-cycle ops, one result per cycle
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            check("vec in_ready", {31'd0, in_ready}, 32'd1);
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            exp_q.push_back(vecs[i].res);
            tick();
            expect_result($sformatf("vec%0d op%0d", i, vecs[i].op), vecs[i].zf);
        end
        idle();
        tick();
        check("vec drained", {31'd0, out_valid}, 32'd0);

        // multiply
        run_multi("mul ff*101", 3'd3, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0);
        run_multi("mul 8000*2", 3'd3, 16'h8000, 16'h0002, 16'h0000, 1'b1);
        run_multi("mul 1234*3", 3'd3, 16'h1234, 16'h0003, 16'h369C, 1'b0);
`ifdef ALU_DIV_EN
        run_multi("div 100/7", 3'd6, 16'd100, 16'd7, 16'd14, 1'b0);
        run_multi("div 5/0", 3'd6, 16'd5, 16'd0, 16'hFFFF, 1'b0);
`endif

        // backpressure: held result, pending op blocked until out_ready rises
        out_ready = 1'b0;
        drive(3'd1, 16'h0005, 16'h0003);
        exp_q.push_back(16'h0008);
        tick();
        drive(3'd1, 16'h0010, 16'h0001);
        for (int k = 0; k < 3; k++) begin
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
            check("bp hold valid", {31'd0, out_valid}, 32'd1);
            check("bp hold data", {16'd0, alu_out}, 32'h0008);
            tick();
        end
        expect_result("bp first", 1'b0);
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(16'h0011);
        tick();
        idle();
        expect_result("bp second", 1'b0);
        tick();
        check("bp drained", {31'd0, out_valid}, 32'd0);
        check("scoreboard empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
